swap_reg_bank: RTL and testbench

SWAP_REG_BANK -- requirements
Module: swap_reg_bank

---
 rtl/swap_reg_bank.sv | 112 +++++++++++
 tb/tb_swap_reg_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/swap_reg_bank.sv
// Register bank with LOAD / SWAP / INC operations, one combinational read port,
// done/err pulses and a sticky INC-overflow flag. All state changes on the falling edge.
module swap_reg_bank #(
    parameter int          WIDTH   = 18,
    parameter int          DEPTH   = 4,
    parameter int unsigned RST_VAL = 3,
    parameter int          SEL_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    input  logic             clr_ovf,
    output logic             done,
    output logic             err,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SWAP = 2'b10,
        OP_INC  = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RST_VAL);
    localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    op_e  op_s;
    logic a_ok, b_ok, idx_ok;

    assign op_s = op_e'(op);
    assign a_ok = 32'(sel_a) < DEPTH_U;
    assign b_ok = 32'(sel_b) < DEPTH_U;
    // sel_b only matters for SWAP; an out-of-range sel_b must not reject LOAD or INC.
    assign idx_ok = a_ok && (op_s != OP_SWAP || b_ok);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        regs_d = regs_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        err_d  = 1'b0;

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (en && op_s != OP_NOP) begin
            if (!idx_ok) begin
                err_d = 1'b1;
            end else begin
                done_d = 1'b1;
                case (op_s)
                    OP_LOAD: regs_d[sel_a] = bus_in;
                    OP_SWAP: begin
                        // Both reads come from the old state, so sel_a == sel_b is a no-op.
                        regs_d[sel_a] = regs_q[sel_b];
                        regs_d[sel_b] = regs_q[sel_a];
                    end
                    OP_INC: begin
                        regs_d[sel_a] = regs_q[sel_a] + WIDTH'(1);
                        if (&regs_q[sel_a]) begin
                            ovf_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            // NOTE: the bank is reset explicitly because RST_VAL must be readable right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RST_WORD;
            end
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_sel) < DEPTH_U) begin
            rd_data = regs_q[rd_sel];
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_swap_reg_bank.sv
// Scoreboard bench for swap_reg_bank: stimulus queues expected responses,
// a monitor pops one per done/err pulse and compares status, read data and ovf.
module tb_swap_reg_bank;

    localparam int W = 18;

    typedef struct packed {
        logic          is_err;
        logic [1:0]    sel;
        logic [W-1:0]  val;
        logic          ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, en, en3, clr_ovf;
    logic [1:0]   op, sel_a, sel_b, rd_sel;
    logic [W-1:0] bus_in;
    logic [W-1:0] rd_data, rd_data3;
    logic         done, err, ovf, done3, err3, ovf3;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    swap_reg_bank u_dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .sel_a(sel_a), .sel_b(sel_b),
        .bus_in(bus_in), .rd_sel(rd_sel), .rd_data(rd_data), .clr_ovf(clr_ovf),
        .done(done), .err(err), .ovf(ovf)
    );

    swap_reg_bank #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .op(op), .sel_a(sel_a), .sel_b(sel_b),
        .bus_in(bus_in), .rd_sel(rd_sel), .rd_data(rd_data3), .clr_ovf(clr_ovf),
        .done(done3), .err(err3), .ovf(ovf3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: DUT state moves on the falling edge, so sample on the rising edge.
    always @(posedge clk) begin
        if (mon_en && (done === 1'b1 || err === 1'b1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: got done=%0b err=%0b expected no response", done, err);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_err", 32'(err), 32'(e.is_err));
                check("resp_done", 32'(done), 32'(!e.is_err));
                check($sformatf("resp_reg%0d", e.sel), 32'(rd_data), 32'(e.val));
                check("resp_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic [1:0] o, input logic [1:0] a,
                         input logic [1:0] b, input logic [W-1:0] d, input logic [1:0] rs,
                         input logic c);
        @(posedge clk);
        #2;
        rst = r; en = e; op = o; sel_a = a; sel_b = b; bus_in = d; rd_sel = rs; clr_ovf = c;
    endtask

    task automatic op_exp(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b,
                          input logic [W-1:0] d, input logic c, input logic [W-1:0] exp_val,
                          input logic exp_ovf);
        exp_t e;
        drive(1'b0, 1'b1, o, a, b, d, a == b || o != 2'b10 ? a : b, c);
        e.is_err = 1'b0;
        e.sel    = rd_sel;
        e.val    = exp_val;
        e.ovf    = exp_ovf;
        q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, '0, rd_sel, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic read_chk(input logic [1:0] s, input logic [W-1:0] exp, input string name);
        rd_sel = s;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en3 = 1'b0; op = 2'b00; sel_a = '0; sel_b = '0;
        bus_in = '0; rd_sel = '0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            read_chk(2'(i), 18'd3, $sformatf("reset_reg%0d", i));
        end
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // LOAD then SWAP on the next edge, the SWAP sees the loaded value.
        op_exp(2'b01, 2'd2, 2'd0, 18'h155AA, 1'b0, 18'h155AA, 1'b0);
        op_exp(2'b10, 2'd2, 2'd0, '0, 1'b0, 18'h155AA, 1'b0);
        idle();
        drain();
        read_chk(2'd2, 18'd3, "swap_reg2");
        read_chk(2'd0, 18'h155AA, "swap_reg0");

        // INC wrap with clr_ovf at the same edge: set wins; then clr_ovf on NOP clears.
        op_exp(2'b01, 2'd1, 2'd0, 18'h3FFFF, 1'b0, 18'h3FFFF, 1'b0);
        op_exp(2'b11, 2'd1, 2'd0, '0, 1'b1, 18'd0, 1'b1);
        drive(1'b0, 1'b1, 2'b00, 2'd1, 2'd0, '0, 2'd1, 1'b1);
        idle();
        drain();
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Plain INC, SWAP of distinct registers, and INC with en=0 ignored.
        op_exp(2'b11, 2'd3, 2'd0, '0, 1'b0, 18'd4, 1'b0);
        op_exp(2'b10, 2'd0, 2'd3, '0, 1'b0, 18'h155AA, 1'b0);
        drive(1'b0, 1'b0, 2'b11, 2'd1, 2'd0, '0, 2'd1, 1'b0);
        idle();
        drain();
        read_chk(2'd0, 18'd4, "swap03_reg0");
        read_chk(2'd1, 18'd0, "inc_disabled_reg1");
        read_chk(2'd2, 18'd3, "untouched_reg2");

        // LOAD under reset is discarded.
        drive(1'b1, 1'b1, 2'b01, 2'd3, 2'd0, 18'd7, 2'd3, 1'b0);
        @(posedge clk);
        #1;
        check("rst_load_done", 32'(done), 32'd0);
        check("rst_load_reg3", 32'(rd_data), 32'd3);
        #1;
        rst = 1'b0; en = 1'b0; op = 2'b00;

        // Self-swap leaves the register alone but still reports done.
        op_exp(2'b01, 2'd1, 2'd0, 18'h0002A, 1'b0, 18'h0002A, 1'b0);
        op_exp(2'b10, 2'd1, 2'd1, '0, 1'b0, 18'h0002A, 1'b0);
        idle();
        drain();

        // DEPTH=3 instance: out-of-range LOAD is rejected with a single err pulse.
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        en3 = 1'b1; op = 2'b01; sel_a = 2'd3; bus_in = 18'h12345;
        @(posedge clk);
        #1;
        check("d3_err_pulse", 32'(err3), 32'd1);
        check("d3_done", 32'(done3), 32'd0);
        #1;
        en3 = 1'b0; op = 2'b00;
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check($sformatf("d3_reg%0d", i), 32'(rd_data3), i < 3 ? 32'd3 : 32'd0);
        end
        @(posedge clk);
        #1;
        check("d3_err_one_cycle", 32'(err3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no completion expected finish before 50000");
        $fatal(1);
    end

endmodule
